// File: rtl/spi_adc_pkg.sv
// Shared types and parameter defaults for the SPI ADC sampler.
package spi_adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TRAIL,
    ST_QUIET
  } state_t;

  localparam int DEF_ADC_RES     = 8;
  localparam int DEF_NUM_CH      = 2;
  localparam int DEF_LEAD_TICKS  = 3;
  localparam int DEF_TRAIL_TICKS = 5;
  localparam int DEF_QUIET_TICKS = 4;
  localparam bit DEF_INVERT_MISO = 1'b1;

endpackage

// File: rtl/spi_adc_shreg.sv
// Per-channel MSB-first shift register; next_o exposes the value after the current shift.
module spi_adc_shreg
  import spi_adc_pkg::*;
#(
  parameter int ADC_RES = DEF_ADC_RES,
  parameter bit INVERT  = DEF_INVERT_MISO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en_i,
  input  logic               miso_i,
  output logic [ADC_RES-1:0] next_o
);

  logic [ADC_RES-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (shift_en_i) begin
      sh_d = {sh_q[ADC_RES-2:0], miso_i ^ INVERT};
    end
  end

  assign next_o = sh_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/spi_adc_sampler.sv
// Multi-channel SPI ADC sampler: shared cs/SCLK, parallel MISO capture, valid/ready result
// register with overrun flag.
//
//   state | meaning
//   IDLE  | waiting for start or continuous, cs high
//   LEAD  | cs low, setup time before first bit
//   SHIFT | cs low, one miso sample per cycle, MSB first
//   TRAIL | cs low, hold time after last bit
//   QUIET | cs high, minimum deselect time (also entered from reset)
module spi_adc_sampler
  import spi_adc_pkg::*;
#(
  parameter int ADC_RES     = DEF_ADC_RES,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int LEAD_TICKS  = DEF_LEAD_TICKS,
  parameter int TRAIL_TICKS = DEF_TRAIL_TICKS,
  parameter int QUIET_TICKS = DEF_QUIET_TICKS,
  parameter bit INVERT_MISO = DEF_INVERT_MISO
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [NUM_CH-1:0]         miso,
  output logic                      cs,
  output logic                      busy,
  output logic [NUM_CH*ADC_RES-1:0] data_out,
  output logic                      data_valid,
  input  logic                      data_ready,
  output logic                      overrun
);

  localparam int LW = $clog2(LEAD_TICKS) + 1;
  localparam int BW = $clog2(ADC_RES) + 1;
  localparam int TW = $clog2(TRAIL_TICKS) + 1;
  localparam int QW = $clog2(QUIET_TICKS) + 1;

  localparam logic [LW-1:0] LEAD_LD  = LW'(LEAD_TICKS - 1);
  localparam logic [BW-1:0] BIT_LD   = BW'(ADC_RES - 1);
  localparam logic [TW-1:0] TRAIL_LD = TW'(TRAIL_TICKS - 1);
  localparam logic [QW-1:0] QUIET_LD = QW'(QUIET_TICKS - 1);

  state_t state_q, state_d;
  logic [LW-1:0] lead_q, lead_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [TW-1:0] trail_q, trail_d;
  logic [QW-1:0] quiet_q, quiet_d;
  logic          shift_en, load;

  logic [NUM_CH*ADC_RES-1:0] next_all, data_q, data_d;
  logic                      valid_q, valid_d, ovr_q, ovr_d;

  // Each phase timer counts down from N-1 and the phase ends when it reads zero.
  always_comb begin
    state_d  = state_q;
    lead_d   = lead_q;
    bit_d    = bit_q;
    trail_d  = trail_q;
    quiet_d  = quiet_q;
    shift_en = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || continuous) begin
          state_d = ST_LEAD;
          lead_d  = LEAD_LD;
        end
      end
      ST_LEAD: begin
        if (lead_q == '0) begin
          state_d = ST_SHIFT;
          bit_d   = BIT_LD;
        end else begin
          lead_d = lead_q - LW'(1);
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (bit_q == '0) begin
          state_d = ST_TRAIL;
          trail_d = TRAIL_LD;
          load    = 1'b1;
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end
      ST_TRAIL: begin
        if (trail_q == '0) begin
          state_d = ST_QUIET;
          quiet_d = QUIET_LD;
        end else begin
          trail_d = trail_q - TW'(1);
        end
      end
      ST_QUIET: begin
        if (quiet_q == '0) begin
          if (continuous) begin
            state_d = ST_LEAD;
            lead_d  = LEAD_LD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          quiet_d = quiet_q - QW'(1);
        end
      end
      default: begin
        state_d = ST_QUIET;
        quiet_d = QUIET_LD;
      end
    endcase
  end

  // The load captures the shift value including the final bit, so the result lands
  // on the cycle right after the last sample.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (load) begin
      data_d  = next_all;
      valid_d = 1'b1;
      ovr_d   = valid_q && !data_ready;
    end else if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_QUIET;
      lead_q  <= '0;
      bit_q   <= '0;
      trail_q <= '0;
      quiet_q <= QUIET_LD;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lead_q  <= lead_d;
      bit_q   <= bit_d;
      trail_q <= trail_d;
      quiet_q <= quiet_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    spi_adc_shreg #(
      .ADC_RES (ADC_RES),
      .INVERT  (INVERT_MISO)
    ) u_shreg (
      .clk        (clk),
      .reset      (reset),
      .shift_en_i (shift_en),
      .miso_i     (miso[k]),
      .next_o     (next_all[k*ADC_RES +: ADC_RES])
    );
  end

  assign cs         = !(state_q inside {ST_LEAD, ST_SHIFT, ST_TRAIL});
  assign busy       = (state_q != ST_IDLE);
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_spi_adc_sampler.sv
// Bench for spi_adc_sampler at default parameters; timing expectations are derived from
// the phase lengths (lead 3, 8 bits, trail 5, quiet 4) relative to the start cycle.
module tb_spi_adc_sampler;

  localparam bit INV = 1'b1;

  logic        clk = 1'b0;
  logic        reset, start, continuous, data_ready;
  logic [1:0]  miso;
  logic        cs, busy, data_valid, overrun;
  logic [15:0] data_out;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  int          base   = -100;
  logic [7:0]  pat [2];
  bit          model_valid = 1'b0;
  logic [15:0] model_data  = '0;

  spi_adc_sampler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .miso       (miso),
    .cs         (cs),
    .busy       (busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] expect_word(input logic [7:0] p0, input logic [7:0] p1);
    return INV ? {~p1, ~p0} : {p1, p0};
  endfunction

  // Advance one cycle; miso carries pattern bits during the 8 sampling cycles of the
  // conversion accepted at cycle 'base', random noise otherwise.
  task automatic step();
    int r;
    @(posedge clk);
    #1;
    cycle++;
    r = cycle - base - 4;
    for (int k = 0; k < 2; k++) begin
      if (r >= 0 && r < 8) miso[k] = pat[k][7-r];
      else                 miso[k] = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b still after %0d cycles, need 0", busy, n);
    end
  endtask

  task automatic consume();
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    model_valid = 1'b0;
    checks++;
    if (data_valid !== 1'b0) begin
      errors++;
      $display("FAIL consume_valid: got %b need 0", data_valid);
    end
    checks++;
    if (data_out !== model_data) begin
      errors++;
      $display("FAIL consume_hold: got %h need %h", data_out, model_data);
    end
  endtask

  // One start-triggered conversion from IDLE, checked every cycle up to IDLE again.
  task automatic run_single(input logic [7:0] p0, input logic [7:0] p1,
                            input bit ready11, input bit poke_start);
    logic [15:0] exp;
    logic [15:0] prev;
    bit          vb;
    exp  = expect_word(p0, p1);
    prev = model_data;
    vb   = model_valid;
    pat[0] = p0;
    pat[1] = p1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_start: busy=%b need 0", busy);
    end
    base  = cycle;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int rel = 1; rel <= 21; rel++) begin
      data_ready = ready11 && (rel == 11);
      start      = poke_start && (rel == 13 || rel == 18);
      checks++;
      if (cs !== !(rel >= 1 && rel <= 16)) begin
        errors++;
        $display("FAIL cs rel=%0d: got %b need %b", rel, cs, !(rel >= 1 && rel <= 16));
      end
      checks++;
      if (busy !== (rel <= 20)) begin
        errors++;
        $display("FAIL busy rel=%0d: got %b need %b", rel, busy, rel <= 20);
      end
      checks++;
      if (data_valid !== ((rel >= 12) ? 1'b1 : vb)) begin
        errors++;
        $display("FAIL data_valid rel=%0d: got %b need %b", rel, data_valid,
                 (rel >= 12) ? 1'b1 : vb);
      end
      checks++;
      if (overrun !== (rel == 12 && vb && !ready11)) begin
        errors++;
        $display("FAIL overrun rel=%0d: got %b need %b", rel, overrun,
                 rel == 12 && vb && !ready11);
      end
      if (rel >= 12 || vb) begin
        checks++;
        if (data_out !== ((rel >= 12) ? exp : prev)) begin
          errors++;
          $display("FAIL data_out rel=%0d: got %h need %h", rel, data_out,
                   (rel >= 12) ? exp : prev);
        end
      end
      if (rel < 21) step();
    end
    start       = 1'b0;
    data_ready  = 1'b0;
    model_valid = 1'b1;
    model_data  = exp;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; continuous = 1'b0; data_ready = 1'b0; miso = '0;
    repeat (3) step();
    checks++;
    if ({cs, busy, data_valid, overrun} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_outputs: cs/busy/valid/ovr=%b need 1100",
               {cs, busy, data_valid, overrun});
    end
    checks++;
    if (data_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_data: got %h need 0000", data_out);
    end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b1 || cs !== 1'b1) begin
        errors++;
        $display("FAIL reset_quiet i=%0d: busy=%b cs=%b need 1 1", i, busy, cs);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_to_idle: busy=%b need 0", busy);
    end
  endtask

  task automatic test_single();
    run_single(8'h5A, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (data_out !== 16'h00A5) begin
      errors++;
      $display("FAIL single_data: got %h need 00a5", data_out);
    end
    consume();
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      run_single(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      if ($urandom_range(1, 0) == 1) consume();
    end
    if (model_valid) consume();
  endtask

  task automatic test_overrun();
    run_single(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    run_single(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    consume();
  endtask

  task automatic test_same_cycle();
    run_single(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    run_single(8'($urandom), 8'($urandom), 1'b1, 1'b0);
    step();
    checks++;
    if (data_valid !== 1'b1 || data_out !== model_data) begin
      errors++;
      $display("FAIL same_cycle_hold: valid=%b data=%h need 1 %h",
               data_valid, data_out, model_data);
    end
    consume();
  endtask

  task automatic test_mid_reset();
    run_single(8'($urandom), 8'($urandom), 1'b0, 1'b0);
    base  = cycle;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    checks++;
    if (cs !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_shift: cs=%b need 0 at rel 8", cs);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    model_valid = 1'b0;
    model_data  = '0;
    checks++;
    if ({cs, busy, data_valid, overrun} !== 4'b1100 || data_out !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs: cs/busy/valid/ovr=%b data=%h need 1100 0000",
               {cs, busy, data_valid, overrun}, data_out);
    end
    for (int rel = 9; rel <= 13; rel++) begin
      checks++;
      if (cs !== 1'b1 || busy !== (rel <= 12)) begin
        errors++;
        $display("FAIL mid_reset_quiet rel=%0d: cs=%b busy=%b need 1 %b",
                 rel, cs, busy, rel <= 12);
      end
      if (rel == 13) begin
        pat[0] = 8'($urandom);
        pat[1] = 8'($urandom);
        base   = cycle;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (cs !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_restart: cs=%b need 0 at rel 14", cs);
    end
    wait_idle();
    model_valid = 1'b1;
    model_data  = expect_word(pat[0], pat[1]);
    checks++;
    if (data_valid !== 1'b1 || data_out !== model_data) begin
      errors++;
      $display("FAIL mid_reset_result: valid=%b data=%h need 1 %h",
               data_valid, data_out, model_data);
    end
    consume();
  endtask

  task automatic test_ignore_start();
    run_single(8'($urandom), 8'($urandom), 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (cs !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ignore_start i=%0d: cs=%b busy=%b need 1 0", i, cs, busy);
      end
    end
    consume();
  endtask

  task automatic test_continuous();
    logic [15:0] exp;
    bit          vb;
    vb = model_valid;
    exp = '0;
    continuous = 1'b1;
    for (int rel = 0; rel <= 60; rel++) begin
      if (rel == 60) continuous = 1'b0;
      if (rel > 0) begin
        checks++;
        if (cs !== !(((rel - 1) % 20) < 16) || busy !== 1'b1) begin
          errors++;
          $display("FAIL continuous rel=%0d: cs=%b busy=%b need %b 1",
                   rel, cs, busy, !(((rel - 1) % 20) < 16));
        end
        checks++;
        if (overrun !== ((rel == 12 && vb) || rel == 32 || rel == 52)) begin
          errors++;
          $display("FAIL continuous_ovr rel=%0d: got %b need %b", rel, overrun,
                   (rel == 12 && vb) || rel == 32 || rel == 52);
        end
      end
      if (rel == 12 || rel == 32 || rel == 52) begin
        checks++;
        if (data_out !== exp || data_valid !== 1'b1) begin
          errors++;
          $display("FAIL continuous_data rel=%0d: got %h v=%b need %h v=1",
                   rel, data_out, data_valid, exp);
        end
      end
      if (rel == 0 || rel == 20 || rel == 40) begin
        pat[0] = 8'($urandom);
        pat[1] = 8'($urandom);
        base   = cycle;
        exp    = expect_word(pat[0], pat[1]);
      end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL continuous_stop: busy=%b need 0", busy);
    end
    model_valid = 1'b1;
    model_data  = exp;
    consume();
  endtask

  initial begin
    test_reset();
    test_single();
    test_random();
    test_overrun();
    test_same_cycle();
    test_ignore_start();
    test_continuous();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
